// File: rtl/systolic_engine_if.sv
// Row-per-beat valid/ready streams of the systolic engine: W and A rows in, C rows out.
interface systolic_engine_if #(
    parameter int N      = 2,
    parameter int DATA_W = 8,
    parameter int ACC_W  = 16
);
    logic                  w_valid;
    logic                  w_ready;
    logic [N*DATA_W-1:0]   w_data;
    logic                  a_valid;
    logic                  a_ready;
    logic [N*DATA_W-1:0]   a_data;
    logic                  c_valid;
    logic                  c_ready;
    logic [N*ACC_W-1:0]    c_data;
    logic                  c_last;

    modport master (
        output w_valid, w_data, a_valid, a_data, c_ready,
        input  w_ready, a_ready, c_valid, c_data, c_last
    );

    modport slave (
        input  w_valid, w_data, a_valid, a_data, c_ready,
        output w_ready, a_ready, c_valid, c_data, c_last
    );
endinterface

// File: rtl/systolic_engine.sv
// Weight-stationary N x N systolic matrix multiplier: C = A x W or C += A x W,
// with stored weights reusable across tiles and a backpressured result stream.
module systolic_engine #(
    parameter int N      = 2,
    parameter int DATA_W = 8,
    parameter int ACC_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              cfg_load_w,
    input  logic              cfg_accum,
    output logic              busy,
    output logic              done,
    systolic_engine_if.slave  bus
);
    localparam int CW = $clog2(N);
    localparam int TW = $clog2(3 * N);
    localparam logic [CW-1:0] LAST_ROW = CW'(N - 1);
    localparam logic [TW-1:0] LAST_CYC = TW'(3 * N - 2);

    typedef enum logic [2:0] {IDLE, LOAD_W, LOAD_A, COMPUTE, OUT} state_t;

    state_t state;
    state_t state_nxt;

    logic [CW-1:0] row;
    logic [TW-1:0] cyc;
    logic          accum_q;
    logic          w_fire;
    logic          a_fire;
    logic          c_fire;

    logic signed [DATA_W-1:0] w_mem  [N][N];
    logic signed [DATA_W-1:0] a_mem  [N][N];
    logic signed [ACC_W-1:0]  res    [N][N];
    logic signed [DATA_W-1:0] a_pipe [N][N];
    logic signed [ACC_W-1:0]  p_pipe [N][N];
    logic signed [DATA_W-1:0] a_in   [N][N];
    logic signed [ACC_W-1:0]  p_in   [N][N];
    logic signed [DATA_W-1:0] feed   [N];

    function automatic logic signed [ACC_W-1:0] mac(
        input logic signed [ACC_W-1:0]  psum,
        input logic signed [DATA_W-1:0] a,
        input logic signed [DATA_W-1:0] w
    );
        logic signed [2*DATA_W-1:0] prod;
        logic signed [ACC_W-1:0]    prod_ext;
        prod     = (2*DATA_W)'(a) * (2*DATA_W)'(w);
        prod_ext = ACC_W'(prod);
        return psum + prod_ext;
    endfunction

    assign w_fire = bus.w_valid & bus.w_ready;
    assign a_fire = bus.a_valid & bus.a_ready;
    assign c_fire = bus.c_valid & bus.c_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = cfg_load_w ? LOAD_W : LOAD_A;
            LOAD_W:  if (w_fire && row == LAST_ROW) state_nxt = LOAD_A;
            LOAD_A:  if (a_fire && row == LAST_ROW) state_nxt = COMPUTE;
            COMPUTE: if (cyc == LAST_CYC) state_nxt = OUT;
            OUT:     if (c_fire && row == LAST_ROW) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Result rows are only presented in OUT so c_data reads 0 everywhere else.
    always_comb begin
        busy        = (state != IDLE);
        bus.w_ready = (state == LOAD_W);
        bus.a_ready = (state == LOAD_A);
        bus.c_valid = (state == OUT);
        bus.c_last  = (state == OUT) && (row == LAST_ROW);
        bus.c_data  = '0;
        if (state == OUT)
            for (int j = 0; j < N; j++)
                bus.c_data[j*ACC_W +: ACC_W] = res[row][j];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            row     <= '0;
            cyc     <= '0;
            accum_q <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= c_fire && (row == LAST_ROW);
            case (state)
                IDLE: if (start) begin
                    row     <= '0;
                    accum_q <= cfg_accum;
                end
                LOAD_W: if (w_fire) row <= (row == LAST_ROW) ? '0 : row + 1'b1;
                LOAD_A: if (a_fire) begin
                    row <= (row == LAST_ROW) ? '0 : row + 1'b1;
                    cyc <= '0;
                end
                COMPUTE: begin
                    cyc <= cyc + 1'b1;
                    if (cyc == LAST_CYC) row <= '0;
                end
                OUT: if (c_fire) row <= (row == LAST_ROW) ? '0 : row + 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int r = 0; r < N; r++)
                for (int c = 0; c < N; c++) begin
                    w_mem[r][c] <= '0;
                    a_mem[r][c] <= '0;
                end
        end else begin
            if (w_fire)
                for (int c = 0; c < N; c++) w_mem[row][c] <= bus.w_data[c*DATA_W +: DATA_W];
            if (a_fire)
                for (int c = 0; c < N; c++) a_mem[row][c] <= bus.a_data[c*DATA_W +: DATA_W];
        end
    end

    // Skew: mesh row r sees A[i][r] at compute cycle i+r, zero otherwise.
    always_comb begin
        for (int r = 0; r < N; r++) begin
            feed[r] = '0;
            if (state == COMPUTE && int'(cyc) >= r && int'(cyc) - r < N)
                feed[r] = a_mem[CW'(int'(cyc) - r)][r];
        end
    end

    for (genvar r = 0; r < N; r++) begin : g_row
        for (genvar c = 0; c < N; c++) begin : g_col
            if (c == 0) begin : g_edge_a
                assign a_in[r][c] = feed[r];
            end else begin : g_pass_a
                assign a_in[r][c] = a_pipe[r][c-1];
            end
            if (r == 0) begin : g_edge_p
                assign p_in[r][c] = '0;
            end else begin : g_pass_p
                assign p_in[r][c] = p_pipe[r-1][c];
            end
        end
    end

    // Mesh is flushed outside COMPUTE so every tile starts from empty pipelines.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset || state != COMPUTE) begin
            for (int r = 0; r < N; r++)
                for (int c = 0; c < N; c++) begin
                    a_pipe[r][c] <= '0;
                    p_pipe[r][c] <= '0;
                end
        end else begin
            for (int r = 0; r < N; r++)
                for (int c = 0; c < N; c++) begin
                    a_pipe[r][c] <= a_in[r][c];
                    p_pipe[r][c] <= mac(p_in[r][c], a_in[r][c], w_mem[r][c]);
                end
        end
    end

    // Column c delivers C[i][c] at compute cycle i+N+c.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int r = 0; r < N; r++)
                for (int c = 0; c < N; c++) res[r][c] <= '0;
        end else if (state == COMPUTE) begin
            for (int c = 0; c < N; c++)
                if (int'(cyc) >= N + c && int'(cyc) - N - c < N)
                    res[CW'(int'(cyc) - N - c)][c] <= accum_q
                        ? res[CW'(int'(cyc) - N - c)][c] + p_pipe[N-1][c]
                        : p_pipe[N-1][c];
        end
    end
endmodule

// File: tb/tb_systolic_engine.sv
// Scoreboard bench for systolic_engine (N=2): expected C rows are queued as A is
// streamed in and popped as result beats are accepted.
module tb_systolic_engine;
    localparam int N      = 2;
    localparam int DATA_W = 8;
    localparam int ACC_W  = 16;

    logic clk        = 1'b0;
    logic reset      = 1'b0;
    logic start      = 1'b0;
    logic cfg_load_w = 1'b0;
    logic cfg_accum  = 1'b0;
    logic busy;
    logic done;

    int total = 0;
    int bad   = 0;

    int stim_w [N][N];
    int stim_a [N][N];
    int model_w[N][N];
    logic signed [ACC_W-1:0] model_c[N][N];
    logic [N*ACC_W-1:0] exp_q[$];

    systolic_engine_if #(.N(N), .DATA_W(DATA_W), .ACC_W(ACC_W)) bus ();

    systolic_engine #(.N(N), .DATA_W(DATA_W), .ACC_W(ACC_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .cfg_load_w (cfg_load_w),
        .cfg_accum  (cfg_accum),
        .busy       (busy),
        .done       (done),
        .bus        (bus.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] expv);
        total++;
        if (got !== expv) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, expv);
        end
    endtask

    task automatic setMats(input int w00, input int w01, input int w10, input int w11,
                           input int a00, input int a01, input int a10, input int a11);
        stim_w[0][0] = w00; stim_w[0][1] = w01; stim_w[1][0] = w10; stim_w[1][1] = w11;
        stim_a[0][0] = a00; stim_a[0][1] = a01; stim_a[1][0] = a10; stim_a[1][1] = a11;
    endtask

    function automatic logic [N*DATA_W-1:0] packW(input int k);
        logic [N*DATA_W-1:0] v;
        for (int j = 0; j < N; j++) v[j*DATA_W +: DATA_W] = DATA_W'(stim_w[k][j]);
        return v;
    endfunction

    function automatic logic [N*DATA_W-1:0] packA(input int k);
        logic [N*DATA_W-1:0] v;
        for (int j = 0; j < N; j++) v[j*DATA_W +: DATA_W] = DATA_W'(stim_a[k][j]);
        return v;
    endfunction

    task automatic modelReset();
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                model_w[r][c] = 0;
                model_c[r][c] = '0;
            end
        exp_q.delete();
    endtask

    task automatic modelCompute(input bit accum);
        logic [N*ACC_W-1:0] row_v;
        int s;
        for (int i = 0; i < N; i++) begin
            for (int c = 0; c < N; c++) begin
                s = 0;
                for (int r = 0; r < N; r++) s += stim_a[i][r] * model_w[r][c];
                model_c[i][c] = accum ? model_c[i][c] + ACC_W'(s) : ACC_W'(s);
                row_v[c*ACC_W +: ACC_W] = model_c[i][c];
            end
            exp_q.push_back(row_v);
        end
    endtask

    // mode: 0 plain, 1 output backpressure, 2 ignored start pulse, 3 reset mid-compute
    task automatic applyStimulus(input bit load_w, input bit accum, input int mode);
        int n;
        logic [N*ACC_W-1:0] expv;
        start = 1'b1; cfg_load_w = load_w; cfg_accum = accum;
        @(negedge clk);
        start = 1'b0; cfg_load_w = 1'b0; cfg_accum = 1'b0;
        checkOutput("busy_after_start", busy, 1);
        checkOutput("w_ready_first", bus.w_ready, load_w);
        checkOutput("a_ready_first", bus.a_ready, !load_w);
        if (load_w) begin
            for (int k = 0; k < N; k++) begin
                bus.w_valid = 1'b1;
                bus.w_data  = packW(k);
                n = 0;
                while (!bus.w_ready && n < 20) begin @(negedge clk); n++; end
                if (!bus.w_ready) checkOutput("w_ready_timeout", 0, 1);
                @(negedge clk);
                for (int j = 0; j < N; j++) model_w[k][j] = stim_w[k][j];
            end
            bus.w_valid = 1'b0;
        end
        for (int k = 0; k < N; k++) begin
            bus.a_valid = 1'b1;
            bus.a_data  = packA(k);
            n = 0;
            while (!bus.a_ready && n < 20) begin @(negedge clk); n++; end
            if (!bus.a_ready) checkOutput("a_ready_timeout", 0, 1);
            @(negedge clk);
        end
        bus.a_valid = 1'b0;
        modelCompute(accum);
        bus.c_ready = (mode != 1);
        n = 1;
        if (mode == 2 || mode == 3) begin start = 1'b1; cfg_load_w = 1'b1; end
        @(negedge clk);
        n = 2;
        start = 1'b0; cfg_load_w = 1'b0;
        if (mode == 3) begin
            reset = 1'b0;
            #1;
            checkOutput("rst_busy", busy, 0);
            checkOutput("rst_done", done, 0);
            checkOutput("rst_w_ready", bus.w_ready, 0);
            checkOutput("rst_a_ready", bus.a_ready, 0);
            checkOutput("rst_c_valid", bus.c_valid, 0);
            checkOutput("rst_c_data", bus.c_data, 0);
            checkOutput("rst_c_last", bus.c_last, 0);
            @(negedge clk);
            reset = 1'b1;
            bus.c_ready = 1'b1;
            modelReset();
            @(negedge clk);
            return;
        end
        while (!bus.c_valid && n < 40) begin @(negedge clk); n++; end
        checkOutput("compute_lat", n, 3 * N);
        if (mode == 1) begin
            for (int h = 0; h < 3; h++) begin
                checkOutput("bp_valid", bus.c_valid, 1);
                if (exp_q.size() > 0) checkOutput("bp_data", bus.c_data, exp_q[0]);
                checkOutput("bp_last", bus.c_last, 0);
                @(negedge clk);
            end
            bus.c_ready = 1'b1;
        end
        for (int k = 0; k < N; k++) begin
            checkOutput("c_valid", bus.c_valid, 1);
            if (exp_q.size() == 0) checkOutput("sb_empty", 1, 0);
            else begin
                expv = exp_q.pop_front();
                checkOutput("c_data", bus.c_data, expv);
            end
            checkOutput("c_last", bus.c_last, k == N - 1);
            @(negedge clk);
        end
        checkOutput("done_pulse", done, 1);
        checkOutput("busy_end", busy, 0);
        checkOutput("c_valid_end", bus.c_valid, 0);
        @(negedge clk);
        checkOutput("done_clear", done, 0);
    endtask

    initial begin
        bus.w_valid = 1'b0; bus.w_data = '0;
        bus.a_valid = 1'b0; bus.a_data = '0;
        bus.c_ready = 1'b1;
        modelReset();
        repeat (2) @(negedge clk);
        checkOutput("init_busy", busy, 0);
        checkOutput("init_done", done, 0);
        checkOutput("init_w_ready", bus.w_ready, 0);
        checkOutput("init_a_ready", bus.a_ready, 0);
        checkOutput("init_c_valid", bus.c_valid, 0);
        checkOutput("init_c_data", bus.c_data, 0);
        checkOutput("init_c_last", bus.c_last, 0);
        reset = 1'b1;
        @(negedge clk);

        $display("[TB] basic multiply");
        setMats(1, 2, 3, 4, 5, 6, 7, 8);
        applyStimulus(1'b1, 1'b0, 0);
        $display("[TB] weight reuse with accumulate");
        applyStimulus(1'b0, 1'b1, 0);
        $display("[TB] output backpressure");
        applyStimulus(1'b1, 1'b0, 1);
        $display("[TB] signed data with ignored start");
        setMats(127, -128, 1, 1, -1, 0, 0, -1);
        applyStimulus(1'b1, 1'b0, 2);
        $display("[TB] accumulator wrap-around");
        setMats(-128, -128, -128, -128, -128, -128, -128, -128);
        applyStimulus(1'b1, 1'b0, 0);
        $display("[TB] reset mid-compute");
        setMats(1, 2, 3, 4, 5, 6, 7, 8);
        applyStimulus(1'b1, 1'b0, 3);
        $display("[TB] reuse after reset");
        applyStimulus(1'b0, 1'b1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
